uart_tx_arb: RTL and testbench

Round-robin arbiter and pacer that shares one uart_tx instance among N_REQ byte producers.
- Accepts one byte at a time through per-requester valid/ready handshakes.
- Drives uart_tx with a single-cycle o_tx_vld pulse.
- Holds off the next grant until the current frame has fully left the line. uart_tx has no busy/ready output, so the arbiter times the frame itself.
- Sits between the producers and uart_tx, on the same FREQ/RATE as that uart_tx.

---
 rtl/uart_tx_arb.sv | 130 +++++++++++++
 tb/tb_uart_tx_arb.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter and frame pacer sharing one uart_tx among
// N_REQ byte producers. Each accepted byte is issued as a one-cycle o_tx_vld
// pulse. The next grant is held off until the frame, plus any configured idle
// gap, has fully left the line.
module uart_tx_arb #(
    parameter int FREQ     = 1_000_000,
    parameter int RATE     = 115_200,
    parameter int N_REQ    = 4,
    parameter int GAP_BITS = 0,
    localparam int IW      = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ*8-1:0] i_req_data,
    input  logic [N_REQ-1:0]   i_req_vld,
    output logic [N_REQ-1:0]   o_req_rdy,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_vld,
    output logic               o_busy,
    output logic [IW-1:0]      o_grant_id
);

    localparam int BIT_CYC   = FREQ / RATE;
    localparam int FRAME_CYC = 10 * BIT_CYC;
    localparam int HOLD_CYC  = FRAME_CYC + GAP_BITS * BIT_CYC;
    localparam int CW        = $clog2(HOLD_CYC + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [IW-1:0]   ptr;
    logic [CW-1:0]   cnt;
    logic            grant_any;
    logic [IW-1:0]   grant_idx;
    logic [IW-1:0]   cand;
    logic            accept;

    // Round-robin search: first valid requester after the pointer, wrapping.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = IW'((32'(ptr) + i) % 32'(N_REQ));
            if (!grant_any && i_req_vld[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign accept = (state == IDLE) && grant_any;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant_any) state_nx = SEND;
            SEND:    state_nx = HOLD;
            HOLD:    if (cnt == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Grant output: one-hot in IDLE only, forced low while in reset.
    always_comb begin
        o_req_rdy = '0;
        if (rst_n && accept) begin
            o_req_rdy = N_REQ'(1) << grant_idx;
        end
    end

    // Datapath: byte latch, pointer, start pulse, busy flag and frame timer.
    // The timer is loaded with HOLD_CYC-1 on accept and counts down through
    // SEND as well as HOLD, so the next accept lands exactly 1+HOLD_CYC
    // cycles after the previous one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr        <= IW'(N_REQ - 1);
            cnt        <= '0;
            o_tx_data  <= 8'h00;
            o_tx_vld   <= 1'b0;
            o_busy     <= 1'b0;
            o_grant_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        o_tx_data  <= i_req_data[{grant_idx, 3'b000} +: 8];
                        ptr        <= grant_idx;
                        o_grant_id <= grant_idx;
                        o_tx_vld   <= 1'b1;
                        o_busy     <= 1'b1;
                        cnt        <= CW'(HOLD_CYC - 1);
                    end
                end
                SEND: begin
                    o_tx_vld <= 1'b0;
                    cnt      <= cnt - CW'(1);
                end
                HOLD: begin
                    if (cnt == '0) begin
                        o_busy <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    o_tx_vld <= 1'b0;
                    o_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: scoreboard bench for uart_tx_arb. A cycle-level reference
// model predicts grants, busy windows and start pulses from the round-robin
// and pacing rules; a separate monitor pops predictions on each o_tx_vld.
module tb_uart_tx_arb;

    localparam int N      = 4;
    localparam int HOLD   = 80;       // 10 bits * 8 cycles
    localparam int GAP_SP = 97;       // 1 + 80 + 2*8

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_vld;
    logic [N-1:0]   req_rdy;
    logic [7:0]     tx_data;
    logic           tx_vld;
    logic           busy;
    logic [1:0]     grant_id;

    logic           g_rst_n = 1'b0;
    logic [N*8-1:0] g_data = 32'h33221100;
    logic [N-1:0]   g_vld = '1;
    logic [N-1:0]   g_rdy;
    logic [7:0]     g_tx_data;
    logic           g_tx_vld;
    logic           g_busy;
    logic [1:0]     g_grant_id;

    always #5 clk = ~clk;

    uart_tx_arb #(.FREQ(1_000_000), .RATE(115_200), .N_REQ(N), .GAP_BITS(0)) dut (
        .clk(clk), .rst_n(rst_n), .i_req_data(req_data), .i_req_vld(req_vld),
        .o_req_rdy(req_rdy), .o_tx_data(tx_data), .o_tx_vld(tx_vld),
        .o_busy(busy), .o_grant_id(grant_id)
    );

    uart_tx_arb #(.FREQ(1_000_000), .RATE(115_200), .N_REQ(N), .GAP_BITS(2)) dut_g (
        .clk(clk), .rst_n(g_rst_n), .i_req_data(g_data), .i_req_vld(g_vld),
        .o_req_rdy(g_rdy), .o_tx_data(g_tx_data), .o_tx_vld(g_tx_vld),
        .o_busy(g_busy), .o_grant_id(g_grant_id)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int         cyc;
        int         id;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];

    // Reference model state: pointer, first cycle the arbiter is free again,
    // and the cycle of the most recent accept.
    int         cyc = 0;
    int         mptr = N - 1;
    int         idle_from = 0;
    int         acc_cyc = -1000;
    logic [N-1:0] xfer = '0;

    always @(negedge clk) begin : model
        logic [N-1:0] er;
        logic         eb;
        int           win;
        exp_t         e;
        er  = '0;
        win = -1;
        eb  = (cyc > acc_cyc) && (cyc < idle_from);
        chk("busy", busy, eb);
        chk("rdy_onehot0", $onehot0(req_rdy), 1);
        if (!rst_n) begin
            chk("rdy_in_reset", req_rdy, 0);
            mptr      = N - 1;
            idle_from = cyc + 1;
            acc_cyc   = cyc;
            sb.delete();
        end else begin
            if (cyc >= idle_from) begin
                for (int i = 1; i <= N; i++) begin
                    if (win < 0 && req_vld[(mptr + i) % N]) win = (mptr + i) % N;
                end
            end
            if (win >= 0) er[win] = 1'b1;
            chk("rdy", req_rdy, er);
            if (win >= 0) begin
                e.cyc  = cyc + 1;
                e.id   = win;
                e.data = req_data[win*8 +: 8];
                sb.push_back(e);
                mptr      = win;
                acc_cyc   = cyc;
                idle_from = cyc + 1 + HOLD;
            end
        end
        xfer = req_rdy & req_vld;
        cyc++;
    end

    // Monitor: pops a prediction whenever the DUT issues a start pulse.
    int mcyc = 0;
    int ids[$];
    int accs[$];
    int blens[$];
    int bcnt = 0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (tx_vld) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_vld_unexpected: got pulse expected none at t=%0t", $time);
            end else begin
                e = sb.pop_front();
                chk("tx_cycle", mcyc, e.cyc);
                chk("tx_data", tx_data, e.data);
                chk("grant_id", grant_id, e.id);
            end
            ids.push_back(int'(grant_id));
            accs.push_back(mcyc - 1);
        end
        if (busy) begin
            bcnt++;
        end else if (bcnt > 0) begin
            blens.push_back(bcnt);
            bcnt = 0;
        end
        mcyc++;
    end

    int gcyc = 0;
    int gacc[$];

    always @(negedge clk) begin : gap_monitor
        if (g_tx_vld) gacc.push_back(gcyc);
        gcyc++;
    end

    // Producer driver: random mode keeps vld/data until a transfer, then
    // optionally raises a fresh request; occasionally withdraws a request.
    int mode = 0;
    bit drop_on_xfer = 1'b0;

    always @(posedge clk) begin : driver
        #1;
        if (mode == 1) begin
            for (int k = 0; k < N; k++) begin
                if (xfer[k] || !req_vld[k]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_vld[k] = 1'b1;
                        req_data[k*8 +: 8] = 8'($urandom);
                    end else begin
                        req_vld[k] = 1'b0;
                    end
                end else if ($urandom_range(0, 99) == 0) begin
                    req_vld[k] = 1'b0;
                end
            end
        end else if (drop_on_xfer) begin
            req_vld = req_vld & ~xfer;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_pulses(input int target, input int budget);
        int b = 0;
        while (ids.size() < target && b < budget) begin
            @(posedge clk);
            b++;
        end
        #2;
        if (ids.size() < target) begin
            checks++;
            errors++;
            $display("FAIL wait_pulses: got %0d pulses expected %0d", ids.size(), target);
        end
    endtask

    function automatic int id_at(input int i);
        return (i < ids.size()) ? ids[i] : -1;
    endfunction

    function automatic int gap_at(input int i);
        return (i + 1 < accs.size()) ? accs[i+1] - accs[i] : -1;
    endfunction

    initial begin
        int exp_order[6] = '{0, 1, 2, 3, 0, 1};
        req_vld  = '0;
        req_data = '0;
        step(3);

        // Test 1: single requester 2 right out of reset.
        rst_n = 1'b1;
        g_rst_n = 1'b1;
        req_data[23:16] = 8'h6A;
        req_vld = 4'b0100;
        drop_on_xfer = 1'b1;
        @(negedge clk);
        chk("t1_rdy_first_cycle", req_rdy, 4'b0100);
        wait_pulses(1, 10);
        chk("t1_grant_id", id_at(0), 2);
        chk("t1_tx_data", tx_data, 8'h6A);
        step(HOLD + 2);
        chk("t1_busy_len", (blens.size() > 0) ? blens[0] : -1, HOLD);

        // Test 2: all four continuously valid from reset.
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        drop_on_xfer = 1'b0;
        req_data = 32'h13121110;
        req_vld  = 4'hF;
        wait_pulses(7, 6 * (HOLD + 1) + 20);
        for (int i = 0; i < 6; i++) chk("t2_order", id_at(1 + i), exp_order[i]);
        for (int i = 1; i < 6; i++) chk("t2_spacing", gap_at(i), HOLD + 1);

        // Test 3: only 1 and 3 with the pointer at 1, then 0 joins mid-hold.
        req_vld = 4'b1010;
        wait_pulses(10, 3 * (HOLD + 1) + 20);
        chk("t3_order0", id_at(7), 3);
        chk("t3_order1", id_at(8), 1);
        chk("t3_order2", id_at(9), 3);
        step(20);
        req_vld = 4'b1011;
        wait_pulses(12, 2 * (HOLD + 1) + 20);
        chk("t3_req0_first", id_at(10), 0);
        chk("t3_req1_next", id_at(11), 1);

        // Test 4: reset pulse in the 40th hold cycle.
        step(39);
        rst_n = 1'b0;
        req_vld = 4'hF;
        step(1);
        rst_n = 1'b1;
        chk("t4_busy", busy, 0);
        chk("t4_tx_vld", tx_vld, 0);
        chk("t4_tx_data", tx_data, 8'h00);
        wait_pulses(13, 10);
        chk("t4_first_grant", id_at(12), 0);

        // Randomised traffic against the model.
        step(HOLD + 2);
        mode = 1;
        step(3000);
        mode = 0;
        drop_on_xfer = 1'b0;
        req_vld = '0;
        step(HOLD + 5);
        chk("sb_drained", sb.size(), 0);

        // GAP_BITS=2 instance spacing.
        chk("gap_spacing0", (gacc.size() > 1) ? gacc[1] - gacc[0] : -1, GAP_SP);
        chk("gap_spacing1", (gacc.size() > 2) ? gacc[2] - gacc[1] : -1, GAP_SP);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
